// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving a dual-port RAM with an asynchronous read port.
// Owns wrap-bit pointers and derives occupancy, level flags and sticky error flags.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    input  logic                  err_clr,
    output logic                  ram_wr_en,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] C_AF_LV = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_AE_LV = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic                r_overflow;
    logic                r_underflow;

    logic [ADDR_WIDTH:0] w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_push_ok;
    logic                w_pop_ok;

    // Handshake: push/pop are requests sampled every cycle; a request is accepted
    // only when the flags of the current cycle allow it (push needs ~full, pop needs
    // ~empty) and reset is low. Refused requests are dropped and flagged as errors.
    always_comb begin
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                    (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
        w_count   = r_wr_ptr - r_rd_ptr;
        w_push_ok = push && !w_full && !reset;
        w_pop_ok  = pop && !w_empty && !reset;
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + C_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + C_ONE;
        end
    end

    // A new error event takes priority over a clear in the same cycle.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && w_full)  r_overflow <= 1'b1;
            else if (err_clr)    r_overflow <= 1'b0;
            if (pop && w_empty)  r_underflow <= 1'b1;
            else if (err_clr)    r_underflow <= 1'b0;
        end
    end

    always_comb begin
        ram_wr_en      = w_push_ok;
        ram_write_data = din;
        ram_write_addr = r_wr_ptr[ADDR_WIDTH-1:0];
        ram_rd_en      = !w_empty;
        ram_read_addr  = r_rd_ptr[ADDR_WIDTH-1:0];
        full           = w_full;
        empty          = w_empty;
        count          = w_count;
        almost_full    = (w_count >= C_AF_LV);
        almost_empty   = (w_count <= C_AE_LV);
        overflow       = r_overflow;
        underflow      = r_underflow;
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios plus randomized traffic, checked against
// a queue-based FIFO model and a behavioural RAM fed by the controller's write port.
module tb_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          wr_clk;
    logic          reset;
    logic          push;
    logic [DW-1:0] din;
    logic          pop;
    logic          err_clr;
    logic          ram_wr_en;
    logic [DW-1:0] ram_write_data;
    logic [AW-1:0] ram_write_addr;
    logic          ram_rd_en;
    logic [AW-1:0] ram_read_addr;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .wr_clk(wr_clk),
        .reset(reset),
        .push(push),
        .din(din),
        .pop(pop),
        .err_clr(err_clr),
        .ram_wr_en(ram_wr_en),
        .ram_write_data(ram_write_data),
        .ram_write_addr(ram_write_addr),
        .ram_rd_en(ram_rd_en),
        .ram_read_addr(ram_read_addr),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    // Clock and behavioural RAM
    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge wr_clk) begin
        if (ram_wr_en) mem[ram_write_addr] <= ram_write_data;
    end

    // Scoreboard / reference model state
    logic [DW-1:0] exp_q[$];
    int            wr_total;
    int            rd_total;
    bit            exp_ov;
    bit            exp_un;
    int            n_vectors;
    int            n_miscompares;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Drive one cycle: set inputs at negedge, check outputs, then advance the model at posedge.
    task automatic drive(input bit rst, input bit ps, input bit pp, input bit ec, input logic [DW-1:0] d);
        int  sz;
        bit  m_full;
        bit  m_empty;
        bit  acc_push;
        bit  acc_pop;
        @(negedge wr_clk);
        reset   = rst;
        push    = ps;
        pop     = pp;
        err_clr = ec;
        din     = d;
        #1;
        sz       = exp_q.size();
        m_full   = (sz == DEPTH);
        m_empty  = (sz == 0);
        acc_push = !rst && ps && !m_full;
        acc_pop  = !rst && pp && !m_empty;
        check("count",        32'(count),          32'(sz));
        check("empty",        32'(empty),          32'(m_empty));
        check("full",         32'(full),           32'(m_full));
        check("almost_full",  32'(almost_full),    32'(sz >= AF));
        check("almost_empty", 32'(almost_empty),   32'(sz <= AE));
        check("overflow",     32'(overflow),       32'(exp_ov));
        check("underflow",    32'(underflow),      32'(exp_un));
        check("ram_wr_en",    32'(ram_wr_en),      32'(acc_push));
        check("ram_rd_en",    32'(ram_rd_en),      32'(!m_empty));
        check("ram_wr_data",  ram_write_data,      d);
        check("ram_wr_addr",  32'(ram_write_addr), 32'(wr_total % DEPTH));
        check("ram_rd_addr",  32'(ram_read_addr),  32'(rd_total % DEPTH));
        if (!m_empty) check("head", mem[ram_read_addr], exp_q[0]);
        @(posedge wr_clk);
        if (rst) begin
            exp_q.delete();
            wr_total = 0;
            rd_total = 0;
            exp_ov   = 1'b0;
            exp_un   = 1'b0;
        end else begin
            if (acc_pop) begin
                void'(exp_q.pop_front());
                rd_total++;
            end
            if (acc_push) begin
                exp_q.push_back(d);
                wr_total++;
            end
            if (ps && m_full) exp_ov = 1'b1;
            else if (ec)      exp_ov = 1'b0;
            if (pp && m_empty) exp_un = 1'b1;
            else if (ec)       exp_un = 1'b0;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, $urandom());
    endtask

    task automatic do_push(input logic [DW-1:0] d);
        drive(1'b0, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic do_pop();
        drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom());
    endtask

    initial begin
        int push_pct;
        int pop_pct;
        n_vectors     = 0;
        n_miscompares = 0;
        wr_total      = 0;
        rd_total      = 0;
        exp_ov        = 1'b0;
        exp_un        = 1'b0;
        reset         = 1'b1;
        push          = 1'b0;
        pop           = 1'b0;
        err_clr       = 1'b0;
        din           = '0;
        repeat (2) @(posedge wr_clk);

        // Reset state, then fill with 0x11..0x88
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle();
        for (int i = 1; i <= DEPTH; i++) do_push(32'(i * 8'h11));
        idle();

        // Overflow on push while full, then clear
        do_push(32'h99);
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle();

        // Drain in order, one extra pop for underflow, then clear
        for (int i = 0; i < DEPTH + 1; i++) do_pop();
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle();

        // Steady-state push+pop across the address wrap
        for (int i = 0; i < 3; i++) do_push($urandom());
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, $urandom());
        for (int i = 0; i < 3; i++) do_pop();

        // Push+pop while full, then while empty
        for (int i = 0; i < DEPTH; i++) do_push($urandom());
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hdead_beef);
        idle();
        for (int i = 0; i < DEPTH - 1; i++) do_pop();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hcafe_f00d);
        idle();
        do_pop();

        // Reset mid-operation with push held high
        for (int i = 0; i < 5; i++) do_push($urandom());
        do_push(32'h1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, $urandom());
        drive(1'b1, 1'b1, 1'b0, 1'b0, $urandom());
        idle();

        // Randomized traffic, alternating fill-biased and drain-biased phases
        for (int blk = 0; blk < 16; blk++) begin
            push_pct = blk[0] ? 25 : 75;
            pop_pct  = blk[0] ? 75 : 25;
            for (int i = 0; i < 40; i++) begin
                drive($urandom_range(0, 99) < 1,
                      $urandom_range(0, 99) < push_pct,
                      $urandom_range(0, 99) < pop_pct,
                      $urandom_range(0, 99) < 5,
                      $urandom());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
